// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: four-state execute/writeback sequencer
// for the 8-bit datapath driving an 8x8 register file.
module alu_exec_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    input  logic [7:0]  rf_rdata1,
    input  logic [7:0]  rf_rdata2,
    output logic        rf_w_en,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        done,
    output logic        illegal,
    output logic        flag_z,
    output logic        flag_c
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    logic [1:0]  state;
    logic [15:0] ir;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [7:0]  result;
    logic        carry;
    logic [8:0]  alu;
    logic        legal;
    logic        is_arith;

    assign legal    = ~ir[15];
    assign is_arith = (ir[14:12] == 3'd0) || (ir[14:12] == 3'd1);

    // Write port and read addresses come straight from latched state
    assign instr_ready = rst_n && (state == IDLE);
    assign rf_raddr1   = ir[8:6];
    assign rf_raddr2   = ir[5:3];
    assign rf_waddr    = ir[11:9];
    assign rf_wdata    = result;
    assign done        = (state == WB);
    assign illegal     = done && !legal;
    assign rf_w_en     = done && legal && (ir[11:9] != 3'd0);

    // ALU: bit 8 carries carry (ADD) or borrow (SUB)
    always_comb begin
        alu = 9'd0;
        if (legal) begin
            case (ir[14:12])
                3'd0: alu = {1'b0, op_a} + {1'b0, op_b};
                3'd1: alu = {(op_a < op_b), op_a - op_b};
                3'd2: alu = {1'b0, op_a & op_b};
                3'd3: alu = {1'b0, op_a | op_b};
                3'd4: alu = {1'b0, op_a ^ op_b};
                3'd5: alu = {1'b0, op_a << op_b[2:0]};
                3'd6: alu = {1'b0, op_a >> op_b[2:0]};
                default: alu = {1'b0, ir[7:0]};
            endcase
        end
    end

    // Sequencer, operand/result registers and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ir     <= 16'd0;
            op_a   <= 8'd0;
            op_b   <= 8'd0;
            result <= 8'd0;
            carry  <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= READ;
                    end
                end
                READ: begin
                    op_a  <= rf_rdata1;
                    op_b  <= rf_rdata2;
                    state <= EXEC;
                end
                EXEC: begin
                    result <= alu[7:0];
                    carry  <= alu[8];
                    state  <= WB;
                end
                default: begin
                    if (legal) begin
                        flag_z <= (result == 8'd0);
                        flag_c <= is_arith && carry;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed self-checking bench with a
// behavioural register file attached to the sequencer.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'd0;
    logic [2:0]  rf_raddr1;
    logic [2:0]  rf_raddr2;
    logic [7:0]  rf_rdata1;
    logic [7:0]  rf_rdata2;
    logic        rf_w_en;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        done;
    logic        illegal;
    logic        flag_z;
    logic        flag_c;

    int checks = 0;
    int failures = 0;

    logic [7:0] rf [8] = '{default: 8'd0};

    alu_exec_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2),
        .rf_w_en(rf_w_en),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .done(done),
        .illegal(illegal),
        .flag_z(flag_z),
        .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    assign rf_rdata1 = (rf_raddr1 == 3'd0) ? 8'd0 : rf[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == 3'd0) ? 8'd0 : rf[rf_raddr2];

    always @(posedge clk) begin
        if (rf_w_en && rf_waddr != 3'd0)
            rf[rf_waddr] <= rf_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op,
        input logic [2:0] rd, input logic [2:0] r1,
        input logic [2:0] r2);
        return {op, rd, r1, r2, 3'b000};
    endfunction

    function automatic logic [15:0] li(input logic [2:0] rd,
        input logic [7:0] imm);
        return {4'h7, rd, 1'b0, imm};
    endfunction

    // Starts and ends on a negedge with the DUT idle
    task automatic run(input string tag, input logic [15:0] ins,
        input logic ewen, input logic [2:0] ewa,
        input logic [7:0] ewd, input logic eill,
        input logic ez, input logic ec);
        instr = ins;
        instr_valid = 1'b1;
        chk({tag, ".rdy0"}, 16'(instr_ready), 16'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk({tag, ".rdy1"}, 16'(instr_ready), 16'd0);
        chk({tag, ".wen1"}, 16'(rf_w_en), 16'd0);
        chk({tag, ".done1"}, 16'(done), 16'd0);
        @(negedge clk);
        chk({tag, ".wen2"}, 16'(rf_w_en), 16'd0);
        chk({tag, ".done2"}, 16'(done), 16'd0);
        @(negedge clk);
        chk({tag, ".done3"}, 16'(done), 16'd1);
        chk({tag, ".wen3"}, 16'(rf_w_en), 16'(ewen));
        chk({tag, ".ill3"}, 16'(illegal), 16'(eill));
        chk({tag, ".waddr"}, 16'(rf_waddr), 16'(ewa));
        if (!eill)
            chk({tag, ".wdata"}, 16'(rf_wdata), 16'(ewd));
        @(negedge clk);
        chk({tag, ".rdy4"}, 16'(instr_ready), 16'd1);
        chk({tag, ".done4"}, 16'(done), 16'd0);
        chk({tag, ".z"}, 16'(flag_z), 16'(ez));
        chk({tag, ".c"}, 16'(flag_c), 16'(ec));
    endtask

    logic [15:0] q [3];

    initial begin
        #2;
        chk("rst.rdy", 16'(instr_ready), 16'd0);
        chk("rst.wen", 16'(rf_w_en), 16'd0);
        chk("rst.done", 16'(done), 16'd0);
        chk("rst.wdata", 16'(rf_wdata), 16'd0);
        chk("rst.flags", {14'd0, flag_z, flag_c}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.rdy", 16'(instr_ready), 16'd1);
        @(negedge clk);

        run("li1", li(3'd1, 8'h7F), 1, 3'd1, 8'h7F, 0, 0, 0);
        run("li2", li(3'd2, 8'h01), 1, 3'd2, 8'h01, 0, 0, 0);
        run("add3", enc(4'h0, 3'd3, 3'd1, 3'd2),
            1, 3'd3, 8'h80, 0, 0, 0);
        run("li4", li(3'd4, 8'hFF), 1, 3'd4, 8'hFF, 0, 0, 0);
        run("li5", li(3'd5, 8'h01), 1, 3'd5, 8'h01, 0, 0, 0);
        run("add6", enc(4'h0, 3'd6, 3'd4, 3'd5),
            1, 3'd6, 8'h00, 0, 1, 1);
        run("sub7", enc(4'h1, 3'd7, 3'd5, 3'd4),
            1, 3'd7, 8'h02, 0, 0, 1);
        run("li1b", li(3'd1, 8'h81), 1, 3'd1, 8'h81, 0, 0, 0);
        run("li2b", li(3'd2, 8'h09), 1, 3'd2, 8'h09, 0, 0, 0);
        run("shl", enc(4'h5, 3'd1, 3'd1, 3'd2),
            1, 3'd1, 8'h02, 0, 0, 0);
        run("li1c", li(3'd1, 8'h80), 1, 3'd1, 8'h80, 0, 0, 0);
        run("li2c", li(3'd2, 8'h07), 1, 3'd2, 8'h07, 0, 0, 0);
        run("shr", enc(4'h6, 3'd3, 3'd1, 3'd2),
            1, 3'd3, 8'h01, 0, 0, 0);
        run("and", enc(4'h2, 3'd5, 3'd4, 3'd2),
            1, 3'd5, 8'h07, 0, 0, 0);
        run("or", enc(4'h3, 3'd6, 3'd1, 3'd2),
            1, 3'd6, 8'h87, 0, 0, 0);
        run("xor", enc(4'h4, 3'd7, 3'd4, 3'd1),
            1, 3'd7, 8'h7F, 0, 0, 0);
        run("li0", li(3'd6, 8'h00), 1, 3'd6, 8'h00, 0, 1, 0);
        run("addr0", enc(4'h0, 3'd0, 3'd4, 3'd4),
            0, 3'd0, 8'hFE, 0, 0, 1);
        run("illA", enc(4'hA, 3'd2, 3'd4, 3'd4),
            0, 3'd2, 8'h00, 1, 0, 1);
        chk("ill.r2", 16'(rf[2]), 16'h07);
        chk("sub.r7x", 16'(rf[7]), 16'h7F);

        q[0] = li(3'd1, 8'h10);
        q[1] = enc(4'h0, 3'd2, 3'd1, 3'd1);
        q[2] = enc(4'h0, 3'd3, 3'd2, 3'd1);
        instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0)
                @(negedge clk);
            if (k < 9 && k % 4 == 0)
                instr = q[k / 4];
            if (k == 9)
                instr_valid = 1'b0;
            chk($sformatf("b2b.rdy%0d", k), 16'(instr_ready),
                16'((k % 4 == 0) && k < 9));
            chk($sformatf("b2b.done%0d", k), 16'(done),
                16'(k % 4 == 3));
        end
        @(negedge clk);
        chk("b2b.r2", 16'(rf[2]), 16'h20);
        chk("b2b.r3", 16'(rf[3]), 16'h30);

        instr = enc(4'h0, 3'd3, 3'd2, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst.rdy", 16'(instr_ready), 16'd0);
        chk("mrst.wen", 16'(rf_w_en), 16'd0);
        chk("mrst.done", 16'(done), 16'd0);
        chk("mrst.waddr", 16'(rf_waddr), 16'd0);
        chk("mrst.wdata", 16'(rf_wdata), 16'd0);
        chk("mrst.raddr", {10'd0, rf_raddr1, rf_raddr2}, 16'd0);
        chk("mrst.flags", {14'd0, flag_z, flag_c}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mrst.wenhold", 16'(rf_w_en), 16'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("mrst.rel", 16'(instr_ready), 16'd1);
        chk("mrst.r3", 16'(rf[3]), 16'h30);
        @(negedge clk);
        run("post", enc(4'h0, 3'd3, 3'd2, 3'd2),
            1, 3'd3, 8'h40, 0, 0, 0);
        chk("post.r3", 16'(rf[3]), 16'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
